// File: rtl/sprite_pkg.sv
// Shared constants for the sprite engine: register map layout, ATTR bit
// positions and helpers that size the CPU address and sprite-id buses.
package sprite_pkg;

  localparam int SLOT_STRIDE = 16;

  localparam logic [3:0] OFF_X    = 4'd12;
  localparam logic [3:0] OFF_Y    = 4'd13;
  localparam logic [3:0] OFF_ATTR = 4'd14;

  localparam int ATTR_EN    = 7;
  localparam int ATTR_HFLIP = 6;
  localparam int ATTR_VFLIP = 5;

  // Byte address width: 16 bytes per slot plus one extra address for COLL.
  // A power-of-two slot count fills the slot space exactly, so COLL needs
  // one more address bit.
  function automatic int calc_addr_w(input int n);
    int w;
    w = $clog2(n) + 4;
    if ((n & (n - 1)) == 0) w = w + 1;
    return w;
  endfunction

  // Width of the winning-sprite index; never narrower than one bit.
  function automatic int calc_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_engine_if.sv
// CPU byte bus shared with the other peripherals.
//
// Handshake: there is no ready. cs is sampled on every rising clk edge.
// cs&rw commits di to addr on that edge. cs&~rw is a read request; dout
// carries the read data from that edge onward and holds it until the next
// read request. Reads of COLL have a side effect (clear), so cs must be
// held for exactly one cycle per intended read.
interface sprite_engine_if #(
  parameter int ADDR_W = 7
);
  logic              cs;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        di;
  logic [7:0]        dout;

  modport master (output cs, output rw, output addr, output di, input dout);
  modport slave  (input cs, input rw, input addr, input di, output dout);
endinterface

// File: rtl/sprite_slot.sv
// One sprite slot: its bitmap/X/Y/ATTR registers and the first pipeline
// stage (hit test, flips, bitmap lookup) for the current beam position.
module sprite_slot
  import sprite_pkg::*;
#(
  parameter int SPRITE_H   = 8,
  parameter int COLOR_BITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [3:0]            off,
  input  logic [7:0]            di,
  output logic [7:0]            rd_data,
  input  logic [7:0]            hpos,
  input  logic [7:0]            vpos,
  output logic                  opaque,
  output logic [COLOR_BITS-1:0] color
);

  // 16 entries so the 4-bit offset indexes directly; only SPRITE_H are used.
  logic [7:0]            bitmap [16];
  logic [7:0]            x_pos;
  logic [7:0]            y_pos;
  logic                  attr_en;
  logic                  attr_hflip;
  logic                  attr_vflip;
  logic [COLOR_BITS-1:0] attr_color;

  logic [7:0] dx;
  logic [7:0] dy;
  logic       hit;
  logic [3:0] row;
  logic [2:0] col;
  logic [7:0] row_bits;
  logic       opaque_n;

  // Bitmap and position registers: CPU writes only, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (off < 4'(SPRITE_H)) begin
        bitmap[off] <= di;
      end else if (off == OFF_X) begin
        x_pos <= di;
      end else if (off == OFF_Y) begin
        y_pos <= di;
      end
    end
  end

  // ATTR register; reset clears it so the slot comes up disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      attr_en    <= 1'b0;
      attr_hflip <= 1'b0;
      attr_vflip <= 1'b0;
      attr_color <= '0;
    end else if (wr_en && off == OFF_ATTR) begin
      attr_en    <= di[ATTR_EN];
      attr_hflip <= di[ATTR_HFLIP];
      attr_vflip <= di[ATTR_VFLIP];
      attr_color <= di[COLOR_BITS-1:0];
    end
  end

  // Read-back of this slot's bytes; unimplemented offsets and ATTR bits read 0.
  always_comb begin
    rd_data = 8'h00;
    if (off < 4'(SPRITE_H)) begin
      rd_data = bitmap[off];
    end else begin
      case (off)
        OFF_X: rd_data = x_pos;
        OFF_Y: rd_data = y_pos;
        OFF_ATTR: begin
          rd_data[ATTR_EN]           = attr_en;
          rd_data[ATTR_HFLIP]        = attr_hflip;
          rd_data[ATTR_VFLIP]        = attr_vflip;
          rd_data[COLOR_BITS-1:0]    = attr_color;
        end
        default: rd_data = 8'h00;
      endcase
    end
  end

  // Hit test and bitmap lookup; subtraction wraps modulo 256 on purpose so
  // sprites straddling the screen edge reappear on the other side.
  always_comb begin
    dx       = hpos - x_pos;
    dy       = vpos - y_pos;
    hit      = attr_en && (dx < 8'd8) && (dy < 8'(SPRITE_H));
    row      = attr_vflip ? (4'(SPRITE_H - 1) - dy[3:0]) : dy[3:0];
    col      = attr_hflip ? ~dx[2:0] : dx[2:0];
    row_bits = bitmap[row];
    opaque_n = hit & row_bits[col];
  end

  // Stage-1 register: per-slot opacity and colour for this beam position.
  always_ff @(posedge clk) begin
    if (reset) begin
      opaque <= 1'b0;
      color  <= '0;
    end else begin
      opaque <= opaque_n;
      color  <= attr_color;
    end
  end

endmodule

// File: rtl/sprite_engine.sv
// Multi-sprite generator: NUM_SPRITES parallel slots, a lowest-index-wins
// priority stage, sticky collision flags and the CPU register read mux.
module sprite_engine
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_H    = 8,
  parameter int COLOR_BITS  = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  sprite_engine_if.slave                     bus,
  input  logic [7:0]                         hpos,
  input  logic [7:0]                         vpos,
  input  logic                               hsync,
  input  logic                               vsync,
  output logic                               pixel,
  output logic [COLOR_BITS-1:0]              color,
  output logic [calc_id_w(NUM_SPRITES)-1:0]  sprite_id
);

  localparam int ADDR_W = calc_addr_w(NUM_SPRITES);
  localparam int ID_W   = calc_id_w(NUM_SPRITES);
  localparam int SLOT_W = ADDR_W - 4;
  localparam logic [ADDR_W-1:0] COLL_ADDR = ADDR_W'(NUM_SPRITES * SLOT_STRIDE);

  logic [SLOT_W-1:0]      slot_idx;
  logic [NUM_SPRITES-1:0] wr_en;
  logic [7:0]             slot_rd    [NUM_SPRITES];
  logic [COLOR_BITS-1:0]  slot_color [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] opaque_v;

  logic                   blank_q;
  logic [NUM_SPRITES-1:0] coll;
  logic [7:0]             dout_q;

  logic                   any_opaque;
  logic                   multi_opaque;
  logic [ID_W-1:0]        win_id;
  logic [COLOR_BITS-1:0]  win_color;
  logic                   pixel_n;
  logic [COLOR_BITS-1:0]  color_n;
  logic [ID_W-1:0]        id_n;
  logic                   coll_set;
  logic                   coll_clr;
  logic                   rd_req;
  logic [7:0]             rd_mux;

  assign slot_idx = bus.addr[ADDR_W-1:4];
  assign rd_req   = bus.cs & ~bus.rw;
  assign coll_clr = rd_req && (bus.addr == COLL_ADDR);
  assign bus.dout = dout_q;

  // Slot write strobes decoded from the upper address bits.
  always_comb begin
    wr_en = '0;
    for (int s = 0; s < NUM_SPRITES; s++) begin
      wr_en[s] = bus.cs && bus.rw && (slot_idx == SLOT_W'(s));
    end
  end

  for (genvar s = 0; s < NUM_SPRITES; s++) begin : g_slot
    sprite_slot #(
      .SPRITE_H  (SPRITE_H),
      .COLOR_BITS(COLOR_BITS)
    ) u_slot (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (wr_en[s]),
      .off    (bus.addr[3:0]),
      .di     (bus.di),
      .rd_data(slot_rd[s]),
      .hpos   (hpos),
      .vpos   (vpos),
      .opaque (opaque_v[s]),
      .color  (slot_color[s])
    );
  end

  // Blanking travels alongside stage 1 so it lines up with opaque_v.
  always_ff @(posedge clk) begin
    if (reset) blank_q <= 1'b0;
    else       blank_q <= hsync | vsync;
  end

  // Priority encoder (lowest index wins) and collision detection.
  always_comb begin
    win_id       = '0;
    win_color    = '0;
    any_opaque   = |opaque_v;
    multi_opaque = |(opaque_v & (opaque_v - 1'b1));
    for (int s = NUM_SPRITES - 1; s >= 0; s--) begin
      if (opaque_v[s]) begin
        win_id    = ID_W'(s);
        win_color = slot_color[s];
      end
    end
    pixel_n  = any_opaque & ~blank_q;
    color_n  = pixel_n ? win_color : '0;
    id_n     = pixel_n ? win_id : '0;
    coll_set = ~blank_q & multi_opaque;
  end

  // Stage-2 register: the visible pixel outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel     <= 1'b0;
      color     <= '0;
      sprite_id <= '0;
    end else begin
      pixel     <= pixel_n;
      color     <= color_n;
      sprite_id <= id_n;
    end
  end

  // Sticky collision flags; a COLL read clears them but a collision seen in
  // the same cycle is OR-ed in after the clear so it is never dropped.
  always_ff @(posedge clk) begin
    if (reset) coll <= '0;
    else       coll <= (coll_clr ? '0 : coll) | (coll_set ? opaque_v : '0);
  end

  // Register read mux: slot bytes, COLL, everything else reads 0.
  always_comb begin
    rd_mux = 8'h00;
    if (bus.addr == COLL_ADDR) begin
      rd_mux[NUM_SPRITES-1:0] = coll;
    end else begin
      for (int s = 0; s < NUM_SPRITES; s++) begin
        if (slot_idx == SLOT_W'(s)) rd_mux = slot_rd[s];
      end
    end
  end

  // Registered read data; holds between reads.
  always_ff @(posedge clk) begin
    if (reset)       dout_q <= 8'h00;
    else if (rd_req) dout_q <= rd_mux;
  end

endmodule

// File: doc/sprite_engine.md
Name: sprite_engine

Overview:
- Parametrised multi-sprite generator: NUM_SPRITES 8-pixel-wide, SPRITE_H-row, 1bpp sprites, each with X/Y position, colour and flip attributes.
- Evaluates all sprites in parallel every clock. Returns one pixel per clock: lowest sprite index has priority. Latches sticky sprite-sprite collision flags.
- Sits between the video timing generator (hpos/vpos/syncs) and the palette/mixer. CPU accesses it through the same cs/rw byte bus used by the other peripherals.

Parameters:
- NUM_SPRITES, 4, sprite slots (1..8).
- SPRITE_H, 8, bitmap rows per sprite (1..12).
- COLOR_BITS, 2, width of per-sprite colour index (1..4).
- ADDR_W, derived localparam = $clog2(NUM_SPRITES)+4 (+1 if NUM_SPRITES is a power of 2): byte address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cs  in  1  chip select.
- rw  in  1  1 = CPU write, 0 = CPU read.
- addr  in  ADDR_W  register byte address.
- di  in  8  write data.
- dout  out  8  registered read data.
- hpos  in  8  current pixel column.
- vpos  in  8  current scanline.
- hsync  in  1  horizontal blank/sync, active-high.
- vsync  in  1  vertical blank/sync, active-high.
- pixel  out  1  sprite pixel opaque.
- color  out  COLOR_BITS  colour index of the winning sprite.
- sprite_id  out  $clog2(NUM_SPRITES) or 1  index of the winning sprite.

Behaviour:
- Register map:
  - Slot s occupies bytes s*16..s*16+15.
  - Offsets 0..SPRITE_H-1 hold bitmap rows; bit n = column n.
  - Offset 12 = X, offset 13 = Y.
  - Offset 14 = ATTR: bit7 enable, bit6 hflip, bit5 vflip, [COLOR_BITS-1:0] colour.
  - Other offsets read 0; writes to them are ignored.
  - Address NUM_SPRITES*16 = COLL: bit s set when slot s collided. Writes ignored.
- CPU bus:
  - Write: cs&rw stores di at the next clk edge.
  - Read: cs&~rw loads dout at the next clk edge (1-cycle read latency). Otherwise dout holds its value.
  - A COLL read returns the current flags and clears them in the same cycle. A collision detected in that same cycle is set after the clear, so it is not lost.
- Reset:
  - pixel=0, color=0, sprite_id=0, dout=0, COLL=0.
  - All ATTR cleared, so every sprite is disabled.
  - Bitmaps, X and Y are not reset.
  - Reset asserted mid-frame forces outputs to 0 from the next edge.
- Pipeline stage 1 (registered), per slot:
  - dx = hpos-X mod 256; dy = vpos-Y mod 256.
  - hit = enable & dx<8 & dy<SPRITE_H.
  - row = dy, or SPRITE_H-1-dy when vflip.
  - col = dx[2:0], or 7-dx[2:0] when hflip.
  - Latch opaque[s] = hit & bitmap[row][col], the slot's colour, and blank = hsync|vsync.
- Pipeline stage 2 (registered):
  - Winner = lowest s with opaque[s].
  - pixel = any opaque & ~blank; color and sprite_id come from the winner.
  - When pixel=0: color=0, sprite_id=0.
  - If ~blank and two or more opaque bits are set: COLL |= opaque.
- Latency: hpos/vpos/sync at edge N produce pixel at edge N+2. Throughput is one pixel per clock with no stall.
- Wrap-around: position arithmetic is modulo 256. A sprite at X=252 shows columns 0..3 at hpos 252..255 and columns 4..7 at hpos 0..3. Same rule vertically.
- A CPU write during active display takes effect from the first stage-1 evaluation after the write edge. No shadowing.

Decomposition:
- Package sprite_pkg holds:
  - ATTR bit positions, register offsets (OFF_X=12, OFF_Y=13, OFF_ATTR=14), SLOT_STRIDE=16.
  - A function computing ADDR_W.
- One natural sub-module, sprite_slot: one slot's registers plus the stage-1 hit, flip and bitmap-lookup logic, instantiated NUM_SPRITES times via generate.
- Priority encoder, COLL register and bus read mux live in sprite_engine.

Test Plan:
- Reset, then scan the full frame with no writes -> pixel=0 everywhere; COLL reads 0x00.
- Slot0: rows all 0x81, X=10, Y=20, ATTR=0x83. At vpos=20: hpos=10 -> pixel=1, color=3, sprite_id=0 two clocks later; hpos=11 -> pixel=0; hpos=17 -> pixel=1; hpos=18 -> pixel=0.
- Flips: slot0 row0=0x01 at X=0, Y=0. ATTR=0xC0 (hflip) -> pixel only at hpos=7, vpos=0. ATTR=0xA0 (vflip, SPRITE_H=8) -> pixel only at hpos=0, vpos=7.
- Priority and collision: slots 0 and 1 both opaque, both at X=50, Y=50, colours 1 and 2 -> at (50,50) color=1, sprite_id=0. COLL read returns 0x03, a second read returns 0x00. Repeat with hsync=1 at that pixel -> pixel=0 and COLL stays 0.
- Wrap: slot2 X=252, row=0xFF, enabled -> pixel=1 for hpos 252..255 and 0..3; pixel=0 at hpos 4.
- Bus: write 0x5A to slot3 offset 12 -> read returns 0x5A one clock after cs&~rw. Read of offset 15 -> 0x00. Reset pulse mid-scanline -> pixel=0 at the next edge; ATTR reads 0x00.
